teak_action_stub_loopback: RTL

Parametrised stub for the kernel action toplevel, replacing fixed-width tie-off stubs in SDAccel test builds. It fetches a configurable number of parameter words through the parameter channels and accumulates them into a checksum. After a programmable delay it signals done. It exposes a readable AXI-lite register file, so host software can check the full go → parameter → done path without a real kernel.

---
 rtl/teak_action_stub_loopback.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/teak_action_stub_loopback.sv
// Loopback stand-in for the kernel action: fetches NUM_PARAMS words, sums them,
// waits DONE_LATENCY cycles, then signals done. Status is readable over AXI-lite.
module teak_action_stub_loopback #(
  parameter int NUM_PARAMS    = 2,
  parameter int DONE_LATENCY  = 4,
  parameter int NUM_SMI_PORTS = 2,
  parameter int SMI_WIDTH     = 72
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               go_0Ready,
  output logic                               go_0Stop,
  output logic                               done_0Ready,
  input  logic                               done_0Stop,
  output logic                               paramaddr_0Ready,
  output logic [31:0]                        paramaddr_0Data,
  input  logic                               paramaddr_0Stop,
  input  logic                               paramdata_0Ready,
  input  logic [31:0]                        paramdata_0Data,
  output logic                               paramdata_0Stop,
  input  logic [31:0]                        s_axi_araddr,
  input  logic [3:0]                         s_axi_arcache,
  input  logic [2:0]                         s_axi_arprot,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [31:0]                        s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  input  logic [31:0]                        s_axi_awaddr,
  input  logic [3:0]                         s_axi_awcache,
  input  logic [2:0]                         s_axi_awprot,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [31:0]                        s_axi_wdata,
  input  logic [3:0]                         s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  output logic [NUM_SMI_PORTS-1:0]           smireq_Ready,
  output logic [NUM_SMI_PORTS*SMI_WIDTH-1:0] smireq_Data,
  input  logic [NUM_SMI_PORTS-1:0]           smireq_Stop,
  input  logic [NUM_SMI_PORTS-1:0]           smiresp_Ready,
  input  logic [NUM_SMI_PORTS*SMI_WIDTH-1:0] smiresp_Data,
  output logic [NUM_SMI_PORTS-1:0]           smiresp_Stop
);

  typedef enum logic [2:0] {IDLE, PADDR, PDATA, DELAY, DONE} state_e;

  // Guarded so a zero-count configuration never produces a negative constant.
  localparam logic [31:0] LAST_IDX = (NUM_PARAMS > 0)   ? 32'(NUM_PARAMS - 1)   : 32'd0;
  localparam logic [31:0] LAST_DLY = (DONE_LATENCY > 0) ? 32'(DONE_LATENCY - 1) : 32'd0;

  state_e      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] dly_q, dly_d;
  logic [31:0] csum_q, csum_d;
  logic [15:0] run_q, run_d;
  logic [15:0] stray_q, stray_d;
  logic [31:0] scr0_q, scr0_d;
  logic [31:0] scr1_q, scr1_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;

  logic [3:0]  smi_hits;
  logic [16:0] stray_sum;
  logic [31:0] rd_mux;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    dly_d            = dly_q;
    csum_d           = csum_q;
    run_d            = run_q;
    go_0Stop         = 1'b1;
    done_0Ready      = 1'b0;
    paramaddr_0Ready = 1'b0;
    paramaddr_0Data  = '0;
    paramdata_0Stop  = 1'b1;
    unique case (state_q)
      IDLE: begin
        go_0Stop = 1'b0;
        if (go_0Ready) begin
          csum_d = '0;
          idx_d  = '0;
          dly_d  = '0;
          if (NUM_PARAMS > 0)        state_d = PADDR;
          else if (DONE_LATENCY > 0) state_d = DELAY;
          else                       state_d = DONE;
        end
      end
      PADDR: begin
        paramaddr_0Ready = 1'b1;
        paramaddr_0Data  = idx_q << 2;
        if (!paramaddr_0Stop) state_d = PDATA;
      end
      PDATA: begin
        paramdata_0Stop = 1'b0;
        if (paramdata_0Ready) begin
          csum_d = csum_q + paramdata_0Data;
          if (idx_q == LAST_IDX) begin
            if (DONE_LATENCY > 0) state_d = DELAY;
            else                  state_d = DONE;
          end else begin
            idx_d   = idx_q + 32'd1;
            state_d = PADDR;
          end
        end
      end
      DELAY: begin
        if (dly_q == LAST_DLY) state_d = DONE;
        else                   dly_d   = dly_q + 32'd1;
      end
      DONE: begin
        done_0Ready = 1'b1;
        if (!done_0Stop) begin
          run_d   = run_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stray SMI responses: popcount per cycle, saturating at 16 bits.
  always_comb begin
    smi_hits = '0;
    for (int i = 0; i < NUM_SMI_PORTS; i++) smi_hits = smi_hits + {3'b0, smiresp_Ready[i]};
    stray_sum = {1'b0, stray_q} + {13'b0, smi_hits};
    stray_d   = stray_sum[16] ? 16'hFFFF : stray_sum[15:0];
  end

  always_comb begin
    unique case (s_axi_araddr[3:2])
      2'd0:    rd_mux = scr0_q;
      2'd1:    rd_mux = scr1_q;
      2'd2:    rd_mux = csum_q;
      default: rd_mux = {stray_q, run_q};
    endcase
  end

  always_comb begin
    arready_d = ~arready_q & ~rvalid_q & s_axi_arvalid;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Writes to CHECKSUM/status addresses fall through and only produce a response.
  always_comb begin
    awready_d = ~awready_q & ~bvalid_q & s_axi_awvalid & s_axi_wvalid;
    bvalid_d  = bvalid_q;
    scr0_d    = scr0_q;
    scr1_d    = scr1_q;
    if (awready_q) begin
      bvalid_d = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) begin
          if (s_axi_awaddr[3:2] == 2'd0) scr0_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
          if (s_axi_awaddr[3:2] == 2'd1) scr1_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
        end
      end
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dly_q     <= '0;
      csum_q    <= '0;
      run_q     <= '0;
      stray_q   <= '0;
      scr0_q    <= '0;
      scr1_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      csum_q    <= csum_d;
      run_q     <= run_d;
      stray_q   <= stray_d;
      scr0_q    <= scr0_d;
      scr1_q    <= scr1_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign smireq_Ready  = '0;
  assign smireq_Data   = '0;
  assign smiresp_Stop  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_awaddr[31:4],
                           s_axi_awaddr[1:0], s_axi_arcache, s_axi_arprot, s_axi_awcache,
                           s_axi_awprot, smireq_Stop, smiresp_Data};

endmodule
